// File: rtl/piso_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_feeder_if
//  Description : Frame handshake and element-strobe bundle for piso_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_feeder_if #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
);
    logic                     valid_i;
    logic                     ready_o;
    logic [WIDTH*COUNT-1:0]   data_i;
    logic                     stall_i;
    logic                     we_o;
    logic [WIDTH-1:0]         data_o;
    logic                     last_o;
    logic                     busy_o;

    // master = upstream source plus downstream sink; slave = the feeder itself
    modport master (
        output valid_i, data_i, stall_i,
        input  ready_o, we_o, data_o, last_o, busy_o
    );

    modport slave (
        input  valid_i, data_i, stall_i,
        output ready_o, we_o, data_o, last_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/piso_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : piso_feeder
//  Description : Buffers a COUNT-element frame and issues one element per cycle
//                as data + write strobe. Define PISO_FEEDER_MSB_FIRST_EN to
//                issue the highest element first.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_feeder #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    piso_feeder_if.slave    bus
);
    localparam int c_idx_w = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(COUNT - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_idx_w-1:0]      w_idx_nxt;
    logic [c_idx_w-1:0]      w_sel;
    logic [WIDTH*COUNT-1:0]  r_buf;
    logic [WIDTH*COUNT-1:0]  w_buf_nxt;
    logic [WIDTH-1:0]        w_elems [COUNT];
    logic                    w_shift;
    logic                    w_at_last;
    logic                    w_we;
    logic                    w_ready;
    logic                    w_accept;

    assign w_shift   = (r_state == c_st_shift);
    assign w_at_last = (r_idx == c_last_idx);
    assign w_we      = w_shift && !bus.stall_i;
    // Ready on the final beat lets the next frame follow with no bubble
    assign w_ready   = !w_shift || (w_at_last && !bus.stall_i);
    assign w_accept  = bus.valid_i && w_ready;

    generate
        for (genvar k = 0; k < COUNT; k++) begin : g_elem
            assign w_elems[k] = r_buf[k*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef PISO_FEEDER_MSB_FIRST_EN
    assign w_sel = c_last_idx - r_idx;
`else
    assign w_sel = r_idx;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_buf_nxt   = r_buf;
        if (w_accept) begin
            w_state_nxt = c_st_shift;
            w_idx_nxt   = '0;
            w_buf_nxt   = bus.data_i;
        end else if (w_we) begin
            if (w_at_last) begin
                w_state_nxt = c_st_idle;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt   = r_idx + c_idx_one;
            end
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.we_o    = w_we;
    assign bus.last_o  = w_we && w_at_last;
    assign bus.busy_o  = w_shift;
    assign bus.data_o  = w_shift ? w_elems[w_sel] : '0;
endmodule
`default_nettype wire

// File: doc/piso_feeder.md
Name: piso_feeder

Overview:
- Parallel-in/serial-out feeder that sits directly upstream of the delay-line shift register.
- Accepts one frame of Count elements over a valid/ready handshake, then issues them one element per cycle as a data + write-enable strobe.
- Output port pair data_o/we_o connects to the shift register's data_i/we_i.
- A downstream stall input freezes issue without losing data.

Parameters:
- Width, 8, bits per element.
- Count, 4, elements per frame; legal range >= 1.
- IdxW (localparam), Count>1 ? $clog2(Count) : 1, width of the element index counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  upstream frame valid.
- ready_o  output  1  feeder can accept a frame this cycle.
- data_i  input  Width*Count  frame; element k = data_i[k*Width +: Width].
- stall_i  input  1  downstream hold; no element issued while high.
- we_o  output  1  element strobe to the downstream shift register.
- data_o  output  Width  current element.
- last_o  output  1  high with we_o on the final element of a frame.
- busy_o  output  1  frame held, elements pending.

Behaviour:
- Reset (rst_ni low, async): state=IDLE, idx=0, frame buffer=0.
  - Resulting outputs: we_o=0, data_o=0, last_o=0, busy_o=0, ready_o=1.
- States:
  - IDLE: no frame held.
  - SHIFT: frame buffered; idx = next element to issue.
- Accept: occurs on the clk_i edge where valid_i && ready_o.
  - data_i is captured into the buffer, idx<=0, state<=SHIFT.
  - data_i is ignored at all other times.
- ready_o (combinational) = (state==IDLE) || (state==SHIFT && idx==Count-1 && !stall_i).
  - This permits back-to-back frames with zero bubble cycles.
- In SHIFT:
  - we_o = !stall_i (combinational).
  - data_o = buffer element idx; data_o is also held valid during stall.
  - last_o = we_o && idx==Count-1.
- Advance: on an edge with we_o high:
  - If idx<Count-1: idx<=idx+1.
  - Else, if valid_i: accept the new frame and stay in SHIFT with idx<=0.
  - Else: state<=IDLE, idx<=0.
- In IDLE: we_o=0, last_o=0, data_o=0.
- busy_o = (state==SHIFT).
- Latency: first element appears on we_o in the cycle after accept, provided stall_i is low.
- Stall: while stall_i is high, idx, buffer and state are frozen and ready_o=0 in SHIFT. No element is dropped or duplicated.
- Count=1: every frame is exactly one beat; idx is constantly 0 and last_o accompanies every we_o.
- valid_i high in SHIFT with idx<Count-1: no accept; upstream must hold data_i stable until ready_o.
- Reset mid-frame: the remaining elements are discarded, outputs return to reset values immediately, and no we_o is produced.

Optional Feature:
- Macro: PISO_FEEDER_MSB_FIRST_EN.
- Defined: elements issue in descending order, i.e. buffer element Count-1-idx is driven on data_o.
- Undefined: ascending order, with element 0 first.
- Handshake, last_o and timing are identical in both builds.

Test Plan:
- Width=8, Count=3, reset then valid_i=1 with data_i=24'h0A0B0C for one cycle.
  - Required: ready_o drops. Next 3 cycles we_o=1 with data_o=0C,0B,0A; last_o=1 only on 0A; then busy_o=0, ready_o=1.
- Same frame with stall_i=1 for 2 cycles after the first beat.
  - Required: we_o=0 and data_o held at 0B during the stall, then 0B,0A issued; total 3 strobes.
- Back-to-back frames 24'h030201 then 24'h060504, valid_i held high.
  - Required: 6 consecutive we_o cycles with data 01..06; last_o on 03 and 06; no gap between frames.
- rst_ni pulsed low after the second beat of a frame 24'h112233.
  - Required: we_o=0, busy_o=0, ready_o=1 immediately; 0x11 is never emitted.
- Count=1, data_i=8'h5A accepted every cycle.
  - Required: we_o=1 and last_o=1 on every cycle with data 5A; ready_o stays 1.
- Built with PISO_FEEDER_MSB_FIRST_EN, Width=8, Count=3, frame 24'h0A0B0C.
  - Required: data_o sequence is 0A,0B,0C, with last_o on 0C.
